// File: rtl/z80_flag_ctrl_if.sv
// z80_flag_ctrl_if: execute-side write requests, instruction framing and z80fi report outputs
interface z80_flag_ctrl_if;
   logic       load_we;
   logic [7:0] load_f;
   logic       alu_we;
   logic [7:0] alu_f;
   logic [7:0] alu_mask;
   logic       fop_we;
   logic [1:0] fop_code;
   logic       ex_af;
   logic       insn_start;
   logic       insn_retire;
   logic [7:0] reg_f;
   logic       fi_valid;
   logic [7:0] fi_f_in;
   logic [7:0] fi_f_out;
   logic       conflict;
   logic       seq_err;
   modport master (
      output load_we, load_f, alu_we, alu_f, alu_mask, fop_we, fop_code, ex_af, insn_start, insn_retire,
      input  reg_f, fi_valid, fi_f_in, fi_f_out, conflict, seq_err
   );
   modport slave (
      input  load_we, load_f, alu_we, alu_f, alu_mask, fop_we, fop_code, ex_af, insn_start, insn_retire,
      output reg_f, fi_valid, fi_f_in, fi_f_out, conflict, seq_err
   );
endinterface

// File: rtl/z80_flag_ctrl.sv
// z80_flag_ctrl: Z80 F/F' register pair with prioritised writes, EX AF,AF' and z80fi before/after capture
module z80_flag_ctrl #(
   parameter logic [7:0] RESET_F = 8'hFF
) (
   input logic            clk,
   input logic            reset_n,
   z80_flag_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;
   state_t     r_state, w_state_nxt;
   logic [7:0] r_f [2];
   logic       r_bank, r_conflict, r_seq_err, r_pend_v;
   logic [7:0] r_fi_in, r_fi_out, r_pend;
   logic [7:0] w_cur, w_oth, w_fop, w_f_new, w_reg_nxt, w_fi_in_nxt;
   logic       w_multi, w_snap, w_cap, w_pend, w_seq_set;
   assign w_cur = r_f[r_bank];
   assign w_oth = r_f[~r_bank];
   // bit order S Z 5 H 3 PV N C
   assign w_fop = (bus.fop_code == 2'd0) ? {w_cur[7:5], 1'b0, w_cur[3:2], 2'b01} :
                  (bus.fop_code == 2'd1) ? {w_cur[7:5], w_cur[0], w_cur[3:2], 1'b0, ~w_cur[0]} :
                  (bus.fop_code == 2'd2) ? {w_cur[7:5], 1'b1, w_cur[3:2], 1'b1, w_cur[0]} : w_cur;
   assign w_f_new = bus.load_we ? bus.load_f :
                    bus.alu_we  ? ((bus.alu_f & bus.alu_mask) | (w_cur & ~bus.alu_mask)) :
                    bus.fop_we  ? w_fop : w_cur;
   assign w_reg_nxt = bus.ex_af ? w_oth : w_f_new;
   assign w_multi = (bus.load_we & bus.alu_we) | (bus.load_we & bus.fop_we) | (bus.alu_we & bus.fop_we);
   always_comb begin
      w_state_nxt = r_state;
      w_snap = 1'b0;
      w_cap = 1'b0;
      w_pend = 1'b0;
      w_seq_set = 1'b0;
      case (r_state)
         IDLE: begin
            w_seq_set = bus.insn_retire;
            w_snap = bus.insn_start;
            w_state_nxt = bus.insn_start ? ACTIVE : IDLE;
         end
         ACTIVE: begin
            w_cap = bus.insn_retire;
            w_pend = bus.insn_retire & bus.insn_start;
            w_snap = ~bus.insn_retire & bus.insn_start;
            w_state_nxt = bus.insn_retire ? REPORT : ACTIVE;
         end
         REPORT: begin
            w_snap = bus.insn_start;
            w_state_nxt = (bus.insn_start || r_pend_v) ? ACTIVE : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end
   // a back-to-back snapshot waits in r_pend until the report has been presented
   assign w_fi_in_nxt = w_snap ? w_cur : (r_state == REPORT && r_pend_v) ? r_pend : r_fi_in;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_f[0]     <= RESET_F;
         r_f[1]     <= RESET_F;
         r_bank     <= 1'b0;
         r_state    <= IDLE;
         r_conflict <= 1'b0;
         r_seq_err  <= 1'b0;
         r_fi_in    <= RESET_F;
         r_fi_out   <= RESET_F;
         r_pend     <= RESET_F;
         r_pend_v   <= 1'b0;
      end else begin
         r_f[r_bank] <= w_f_new;
         r_bank      <= r_bank ^ bus.ex_af;
         r_state     <= w_state_nxt;
         r_conflict  <= w_multi;
         r_seq_err   <= r_seq_err | w_seq_set;
         r_fi_in     <= w_fi_in_nxt;
         r_pend_v    <= w_pend;
         if (w_pend) r_pend <= w_cur;
         if (w_cap) r_fi_out <= w_reg_nxt;
      end
   end
   assign bus.reg_f    = w_cur;
   assign bus.fi_valid = (r_state == REPORT);
   assign bus.fi_f_in  = r_fi_in;
   assign bus.fi_f_out = r_fi_out;
   assign bus.conflict = r_conflict;
   assign bus.seq_err  = r_seq_err;
endmodule
